// File: rtl/frac_pkg.sv
// Shared constants and FSM encoding for the frac_search front end.
// Used by frac_row_feeder, its block buffer and the frac_search bench.
package frac_pkg;

    localparam int PIX_W = 8;
    localparam int BLK_N = 8;
    localparam int ROW_W = 64;
    localparam int ORG_W = 48;
    localparam int SAD_W = 12;
    localparam int MV_W  = 3;
    localparam int RA_W  = 3;
    localparam int CNT_W = 4;
    localparam int WCN_W = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT,
        S_CAPT
    } state_t;

endpackage

// File: rtl/frac_row_feeder_if.sv
// Bus bundle between block loader / frac_search and frac_row_feeder.
// slave = feeder side, master = loader + frac_search side.
interface frac_row_feeder_if;
    import frac_pkg::*;

    logic             wr_en;
    logic             wr_sel;
    logic [RA_W-1:0]  wr_row;
    logic [ROW_W-1:0] wr_data;
    logic             wr_err;
    logic             start;
    logic             busy;
    logic [ROW_W-1:0] cur_pix;
    logic [ORG_W-1:0] org_pix;
    logic             ready;
    logic [SAD_W-1:0] sad_in;
    logic [MV_W-1:0]  mvx_in;
    logic [MV_W-1:0]  mvy_in;
    logic [SAD_W-1:0] res_sad;
    logic [MV_W-1:0]  res_mvx;
    logic [MV_W-1:0]  res_mvy;
    logic             res_valid;

    modport master (
        output wr_en, wr_sel, wr_row, wr_data,
        output start, sad_in, mvx_in, mvy_in,
        input  wr_err, busy, cur_pix, org_pix, ready,
        input  res_sad, res_mvx, res_mvy, res_valid
    );

    modport slave (
        input  wr_en, wr_sel, wr_row, wr_data,
        input  start, sad_in, mvx_in, mvy_in,
        output wr_err, busy, cur_pix, org_pix, ready,
        output res_sad, res_mvx, res_mvy, res_valid
    );

endinterface

// File: rtl/frac_blk_buf.sv
// Block buffer: 8 current rows + 8 original rows, one write port,
// async read ports for a current row and an original row (inner 6 px).
// Ports: clk; we/wsel/wrow/wdata write; cur_addr->cur_row; org_addr->org_row.
module frac_blk_buf
    import frac_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic             wsel,
    input  logic [RA_W-1:0]  wrow,
    input  logic [ROW_W-1:0] wdata,
    input  logic [RA_W-1:0]  cur_addr,
    output logic [ROW_W-1:0] cur_row,
    input  logic [RA_W-1:0]  org_addr,
    output logic [ORG_W-1:0] org_row
);

    // Edge pixels 0 and 7 of an original row are never read
    // downstream, so only the inner six are kept.
    logic [ROW_W-1:0] cur_mem [BLK_N];
    logic [ORG_W-1:0] org_mem [BLK_N];

    always_ff @(posedge clk) begin
        if (we) begin
            if (wsel)
                org_mem[wrow] <= wdata[ORG_W+PIX_W-1:PIX_W];
            else
                cur_mem[wrow] <= wdata;
        end
    end

    assign cur_row = cur_mem[cur_addr];
    assign org_row = org_mem[org_addr];

endmodule

// File: rtl/frac_row_feeder.sv
// Streams buffered cur/org blocks to frac_search in skewed row order
// and captures its sad/mv result. Ports: clk, reset, bus (slave).
module frac_row_feeder
    import frac_pkg::*;
#(
    parameter int RESULT_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    frac_row_feeder_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BLK_N);
    localparam logic [WCN_W-1:0] WAIT_LAST = WCN_W'(RESULT_LAT - 2);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [WCN_W-1:0] wcnt;
    logic [WCN_W-1:0] wcnt_n;
    logic             start_q;
    logic             strm_n;
    logic [RA_W-1:0]  cur_addr;
    logic [RA_W-1:0]  org_addr;
    logic [ROW_W-1:0] cur_row;
    logic [ORG_W-1:0] org_row;
    logic             buf_we;

    assign buf_we = bus.wr_en && (state == S_IDLE);

    // Row addresses follow the next cycle's cnt because the pixel
    // outputs are registered. org lags cur by one row; at cnt=8
    // cnt[2:0]-1 wraps to 7 and cur holds at row 7.
    assign cur_addr = cnt_n[3] ? RA_W'(BLK_N - 1) : cnt_n[RA_W-1:0];
    assign org_addr = cnt_n[RA_W-1:0] - RA_W'(1);

    frac_blk_buf u_buf (
        .clk      (clk),
        .we       (buf_we),
        .wsel     (bus.wr_sel),
        .wrow     (bus.wr_row),
        .wdata    (bus.wr_data),
        .cur_addr (cur_addr),
        .cur_row  (cur_row),
        .org_addr (org_addr),
        .org_row  (org_row)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        wcnt_n  = wcnt;
        unique case (state)
            S_IDLE: begin
                if (start_q) begin
                    state_n = S_STREAM;
                    cnt_n   = '0;
                end
            end
            S_STREAM: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    wcnt_n  = '0;
                    state_n = (RESULT_LAT == 1) ? S_CAPT : S_WAIT;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (wcnt == WAIT_LAST)
                    state_n = S_CAPT;
                else
                    wcnt_n = wcnt + WCN_W'(1);
            end
            S_CAPT: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign strm_n = (state_n == S_STREAM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            wcnt          <= '0;
            start_q       <= 1'b0;
            bus.ready     <= 1'b0;
            bus.busy      <= 1'b0;
            bus.cur_pix   <= '0;
            bus.org_pix   <= '0;
            bus.wr_err    <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_sad   <= '0;
            bus.res_mvx   <= '0;
            bus.res_mvy   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            wcnt    <= wcnt_n;
            // One-cycle arm so the burst starts the edge after start.
            start_q <= bus.start && (state == S_IDLE) && !start_q;
            bus.ready   <= strm_n;
            bus.busy    <= (state_n != S_IDLE);
            bus.cur_pix <= strm_n ? cur_row : '0;
            bus.org_pix <= (strm_n && cnt_n != '0) ? org_row : '0;
            bus.wr_err  <= bus.wr_en && (state != S_IDLE);
            bus.res_valid <= (state == S_CAPT);
            if (state == S_CAPT) begin
                bus.res_sad <= bus.sad_in;
                bus.res_mvx <= bus.mvx_in;
                bus.res_mvy <= bus.mvy_in;
            end
        end
    end

endmodule

// File: tb/tb_frac_row_feeder.sv
// Scoreboard bench for frac_row_feeder: queued expected rows/results
// from a block-level model, checked by a negedge monitor.
module tb_frac_row_feeder;
    import frac_pkg::*;

    typedef struct packed {
        logic [63:0] cur;
        logic [47:0] org;
    } row_t;

    typedef struct packed {
        logic [11:0] sad;
        logic [2:0]  mx;
        logic [2:0]  my;
    } res_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    frac_row_feeder_if bus();

    frac_row_feeder #(.RESULT_LAT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_res   = 0;

    row_t exp_rows[$];
    res_t exp_res[$];
    logic [63:0] cur_m [8];
    logic [63:0] org_m [8];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rep(input logic [7:0] b);
        return {8{b}};
    endfunction

    always @(negedge clk) begin : mon
        row_t e;
        res_t r;
        if (reset === 1'b0) begin
            if (bus.ready) begin
                if (exp_rows.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL ready_extra: got ready=1, expected 0");
                end else begin
                    e = exp_rows.pop_front();
                    chk("cur_pix", bus.cur_pix, e.cur);
                    chk("org_pix", 64'(bus.org_pix), 64'(e.org));
                end
            end else begin
                chk("cur_pix_idle", bus.cur_pix, 64'd0);
                chk("org_pix_idle", 64'(bus.org_pix), 64'd0);
            end
            if (bus.res_valid) begin
                n_res++;
                if (exp_res.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL res_extra: got res_valid=1, expected 0");
                end else begin
                    r = exp_res.pop_front();
                    chk("res_sad", 64'(bus.res_sad), 64'(r.sad));
                    chk("res_mvx", 64'(bus.res_mvx), 64'(r.mx));
                    chk("res_mvy", 64'(bus.res_mvy), 64'(r.my));
                end
            end
        end
    end

    task automatic wr(input logic sel, input logic [2:0] row,
                      input logic [63:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_row  = row;
        bus.wr_data = d;
        step();
        bus.wr_en = 1'b0;
        if (sel) org_m[row] = d;
        else     cur_m[row] = d;
        chk("wr_err_idle", 64'(bus.wr_err), 64'd0);
    endtask

    // mode 0 plain, 1 start at cnt 4, 2 write at cnt 2,
    // 3 reset at cnt 5, 4 write row 0 together with start
    task automatic burst(input int mode, input logic [11:0] s,
                         input logic [2:0] mx, input logic [2:0] my);
        row_t e;
        res_t r;
        int   lat;
        int   nb;
        bus.sad_in = s;
        bus.mvx_in = mx;
        bus.mvy_in = my;
        if (mode == 4) begin
            bus.wr_en   = 1'b1;
            bus.wr_sel  = 1'b0;
            bus.wr_row  = 3'd0;
            bus.wr_data = '1;
            cur_m[0]    = '1;
        end
        bus.start = 1'b1;
        for (int n = 0; n < 9; n++) begin
            e.cur = cur_m[(n > 7) ? 7 : n];
            e.org = (n == 0) ? 48'd0 : org_m[n-1][55:8];
            exp_rows.push_back(e);
        end
        r.sad = s;
        r.mx  = mx;
        r.my  = my;
        if (mode != 3) exp_res.push_back(r);
        nb = n_res;
        step();
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            step();
            if (i == 1) chk("busy_stream", 64'(bus.busy), 64'd1);
            if (mode == 1 && i == 5) bus.start = 1'b1;
            if (mode == 1 && i == 6) bus.start = 1'b0;
            if (mode == 2 && i == 3) begin
                bus.wr_en   = 1'b1;
                bus.wr_sel  = 1'b0;
                bus.wr_row  = 3'd3;
                bus.wr_data = {$urandom, $urandom};
            end
            if (mode == 2 && i == 4) begin
                bus.wr_en = 1'b0;
                chk("wr_err_pulse", 64'(bus.wr_err), 64'd1);
            end
            if (mode == 3 && i == 6) begin
                reset = 1'b1;
                #1;
                chk("rst_ready", 64'(bus.ready), 64'd0);
                chk("rst_busy", 64'(bus.busy), 64'd0);
                chk("rst_cur", bus.cur_pix, 64'd0);
                chk("rst_org", 64'(bus.org_pix), 64'd0);
                chk("rst_sad", 64'(bus.res_sad), 64'd0);
                exp_rows.delete();
                exp_res.delete();
                step();
                reset = 1'b0;
            end
            if (bus.res_valid) begin
                lat = i;
                chk("busy_done", 64'(bus.busy), 64'd0);
            end
        end
        chk("latency", 64'(lat), (mode == 3) ? 64'd0 : 64'd11);
        repeat (4) step();
        chk("rows_left", 64'(exp_rows.size()), 64'd0);
        chk("res_count", 64'(n_res - nb), (mode == 3) ? 64'd0 : 64'd1);
        chk("busy_idle", 64'(bus.busy), 64'd0);
        chk("wr_err_idle2", 64'(bus.wr_err), 64'd0);
        if (mode != 3)
            chk("res_hold", 64'(bus.res_sad), 64'(s));
    endtask

    initial begin
        int m;
        bus.wr_en   = 1'b0;
        bus.wr_sel  = 1'b0;
        bus.wr_row  = 3'd0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        bus.sad_in  = '0;
        bus.mvx_in  = '0;
        bus.mvy_in  = '0;
        repeat (2) step();
        chk("reset_ready", 64'(bus.ready), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_cur", bus.cur_pix, 64'd0);
        chk("reset_org", 64'(bus.org_pix), 64'd0);
        chk("reset_err", 64'(bus.wr_err), 64'd0);
        chk("reset_rv", 64'(bus.res_valid), 64'd0);
        chk("reset_res", 64'({bus.res_sad, bus.res_mvx, bus.res_mvy}), 64'd0);
        reset = 1'b0;
        step();

        for (int r = 0; r < 8; r++) begin
            wr(1'b0, 3'(r), rep(8'(r)));
            wr(1'b1, 3'(r), rep(8'(8'h10 + r)));
        end
        burst(0, 12'h123, 3'd5, 3'd2);
        burst(1, 12'h456, 3'd1, 3'd7);
        burst(2, 12'h789, 3'd3, 3'd4);
        burst(0, 12'h0AB, 3'd6, 3'd0);
        burst(4, 12'hFFF, 3'd7, 3'd7);
        burst(3, 12'h321, 3'd2, 3'd1);
        burst(0, 12'h555, 3'd4, 3'd3);

        for (int k = 0; k < 8; k++) begin
            for (int w = 0; w < 4; w++)
                wr(1'($urandom), 3'($urandom), {$urandom, $urandom});
            m = $urandom_range(0, 3);
            burst((m == 3) ? 4 : m, 12'($urandom),
                  3'($urandom), 3'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
